bp_update_scheduler: RTL and testbench

//   Collects resolved-branch records from two requesters (0 = commit stage, 1 = branch ALU).

---
 rtl/bp_pkg.sv | 13 +
 rtl/bp_update_fifo.sv | 61 ++++++
 rtl/bp_update_scheduler.sv | 99 +++++++++
 tb/tb_bp_update_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update path.
//   ADDR_W   : branch address width seen by the predictor update port
//   bp_rec_t : one resolved-branch record (address + resolved direction)
package bp_pkg;

  localparam int ADDR_W = 17;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              take;
  } bp_rec_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Circular-buffer FIFO of bp_rec_t records.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail (caller guarantees ~full)
//   push_data  : record to write
//   pop        : drop the head entry (caller guarantees ~empty)
//   clear      : synchronous discard of all entries; overrides push/pop
//   head       : entry at rd_ptr, driven from registered state
//   full/empty : occupancy flags from the registered count
//   count      : number of stored entries
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  bp_rec_t       push_data,
  input  logic          pop,
  input  logic          clear,
  output bp_rec_t       head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  bp_rec_t         mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_update_scheduler.sv
// Collects resolved-branch records from the commit stage (requester 0) and the
// branch ALU (requester 1), round-robin arbitrates them into a small FIFO and
// drains at most one record per cycle into the predictor update port.
//   clk, rst                  : clock, asynchronous active-high reset
//   req_valid[1:0]            : per-requester record valid
//   req_addr0/req_take0       : requester 0 record
//   req_addr1/req_take1       : requester 1 record
//   req_ready[1:0]            : per-requester accept (one-hot or zero)
//   hold                      : predictor cannot take an update this cycle
//   flush                     : discard every queued record
//   record_en/addr/take       : predictor update strobe and payload
//   issued_cnt / dropped_cnt  : saturating counts of updates issued / flushed
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic              req_take0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic              req_take1,
  output logic [1:0]        req_ready,
  input  logic              hold,
  input  logic              flush,
  output logic              record_en,
  output logic [ADDR_W-1:0] record_addr,
  output logic              record_take,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  dropped_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic              rr_ptr;
  logic              gnt_idx;
  logic              push;
  bp_rec_t           push_data;
  bp_rec_t           head;
  logic              full;
  logic              empty;
  logic [AW:0]       fifo_count;
  logic [CNT_W:0]    drop_sum;

  // rr_ptr only matters on contention; a lone requester always wins.
  always_comb begin
    gnt_idx = 1'b0;
    if (req_valid == 2'b11) gnt_idx = rr_ptr;
    else if (req_valid[1])  gnt_idx = 1'b1;
  end

  // full uses the registered count, so a same-cycle pop never makes room.
  always_comb begin
    req_ready = 2'b00;
    if ((req_valid != 2'b00) && !full && !flush && !rst)
      req_ready[gnt_idx] = 1'b1;
  end

  assign push      = |(req_valid & req_ready);
  assign push_data = gnt_idx ? '{addr: req_addr1, take: req_take1}
                             : '{addr: req_addr0, take: req_take0};

  assign record_en   = !empty && !hold && !flush && !rst;
  assign record_addr = head.addr;
  assign record_take = head.take;

  bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (record_en),
    .clear     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign drop_sum = {1'b0, dropped_cnt} + (CNT_W+1)'(fifo_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= 1'b0;
      issued_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      if (push) rr_ptr <= ~gnt_idx;
      if (record_en && (issued_cnt != '1))
        issued_cnt <= issued_cnt + CNT_W'(1);
      if (flush)
        dropped_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
module tb_bp_update_scheduler;
  import bp_pkg::*;

  localparam int    DEPTH   = 4;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0, req_addr1;
  logic              req_take0, req_take1;
  logic [1:0]        req_ready;
  logic              hold, flush;
  logic              record_en;
  logic [ADDR_W-1:0] record_addr;
  logic              record_take;
  logic [31:0]       issued_cnt, dropped_cnt;

  bp_update_scheduler #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr0   (req_addr0),
    .req_take0   (req_take0),
    .req_addr1   (req_addr1),
    .req_take1   (req_take1),
    .req_ready   (req_ready),
    .hold        (hold),
    .flush       (flush),
    .record_en   (record_en),
    .record_addr (record_addr),
    .record_take (record_take),
    .issued_cnt  (issued_cnt),
    .dropped_cnt (dropped_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic              t;
  } rec_t;

  rec_t   q[$];
  int     rr;
  longint m_issued, m_dropped;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rr        = 0;
    m_issued  = 0;
    m_dropped = 0;
  endtask

  // One cycle: drive at the negedge, check mid-cycle, advance the model at the edge.
  task automatic step(input logic [1:0] v, input logic [ADDR_W-1:0] a0, input logic t0,
                      input logic [ADDR_W-1:0] a1, input logic t1,
                      input logic h, input logic f);
    int         g;
    logic [1:0] exp_ready;
    logic       exp_en;
    rec_t       r;
    req_valid = v; req_addr0 = a0; req_take0 = t0;
    req_addr1 = a1; req_take1 = t1; hold = h; flush = f;
    #1;
    g         = (v == 2'b11) ? rr : (v[1] ? 1 : 0);
    exp_ready = (v != 2'b00 && q.size() < DEPTH && !f) ? 2'(1 << g) : 2'b00;
    exp_en    = (q.size() > 0) && !h && !f;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("record_en", 64'(record_en), 64'(exp_en));
    if (q.size() > 0) begin
      chk("record_addr", 64'(record_addr), 64'(q[0].a));
      chk("record_take", 64'(record_take), 64'(q[0].t));
    end
    chk("issued_cnt", 64'(issued_cnt), 64'(m_issued));
    chk("dropped_cnt", 64'(dropped_cnt), 64'(m_dropped));
    @(posedge clk);
    if (f) begin
      m_dropped += q.size();
      if (m_dropped > CNT_MAX) m_dropped = CNT_MAX;
      q.delete();
    end else begin
      if (exp_en) begin
        void'(q.pop_front());
        if (m_issued < CNT_MAX) m_issued++;
      end
      if (exp_ready != 2'b00) begin
        r.a = (g == 1) ? a1 : a0;
        r.t = (g == 1) ? t1 : t0;
        q.push_back(r);
        rr = 1 - g;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic h);
    step(2'b00, '0, 1'b0, '0, 1'b0, h, 1'b0);
  endtask

  initial begin
    req_valid = 0; req_addr0 = 0; req_take0 = 0; req_addr1 = 0; req_take1 = 0;
    hold = 0; flush = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_en", 64'(record_en), 64'd0);
    chk("rst_addr", 64'(record_addr), 64'd0);
    chk("rst_take", 64'(record_take), 64'd0);
    chk("rst_issued", 64'(issued_cnt), 64'd0);
    chk("rst_dropped", 64'(dropped_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single record from requester 0, drained next cycle
    step(2'b01, 17'h00123, 1'b1, 17'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // contention under hold: alternating grants until full, then in-order drain
    step(2'b11, 17'h00a00, 1'b0, 17'h01b01, 1'b1, 1'b1, 1'b0);
    step(2'b11, 17'h00a02, 1'b1, 17'h01b03, 1'b0, 1'b1, 1'b0);
    step(2'b11, 17'h00a04, 1'b0, 17'h01b05, 1'b1, 1'b1, 1'b0);
    step(2'b11, 17'h00a06, 1'b1, 17'h01b07, 1'b0, 1'b1, 1'b0);
    step(2'b11, 17'h00a08, 1'b0, 17'h01b09, 1'b1, 1'b1, 1'b0);
    repeat (5) idle(1'b0);

    // full with drain active: push refused, accepted next cycle
    for (int i = 0; i < DEPTH; i++)
      step(2'b01, 17'(17'h02000 + i), 1'b1, '0, 1'b0, 1'b1, 1'b0);
    step(2'b01, 17'h02100, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(2'b01, 17'h02101, 1'b1, '0, 1'b0, 1'b1, 1'b0);
    step(2'b01, 17'h02102, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    repeat (6) idle(1'b0);

    // flush with three entries queued
    for (int i = 0; i < 3; i++)
      step(2'b01, 17'(17'h03000 + i), 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(2'b10, '0, 1'b0, 17'h03300, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    chk("dropped_after_flush", 64'(dropped_cnt), 64'd3);

    // asynchronous reset mid-drain
    step(2'b01, 17'h04000, 1'b1, '0, 1'b0, 1'b1, 1'b0);
    step(2'b10, '0, 1'b0, 17'h04001, 1'b0, 1'b1, 1'b0);
    req_valid = 2'b00; hold = 1'b0;
    #1;
    chk("pre_rst_en", 64'(record_en), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_en", 64'(record_en), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd0);
    chk("async_rst_addr", 64'(record_addr), 64'd0);
    chk("async_rst_issued", 64'(issued_cnt), 64'd0);
    chk("async_rst_dropped", 64'(dropped_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    repeat (3) idle(1'b0);

    // issued_cnt saturation
    step(2'b01, 17'h05000, 1'b1, '0, 1'b0, 1'b1, 1'b0);
    force dut.issued_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.issued_cnt;
    m_issued = CNT_MAX;
    idle(1'b0);
    idle(1'b0);
    chk("issued_saturated", 64'(issued_cnt), 64'hFFFF_FFFF);

    // randomized traffic against the queue model
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      step(2'($urandom_range(0, 3)),
           17'($urandom), 1'($urandom),
           17'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
